// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - phase codes, defaults and state type for the CPU phase sequencer
package cpu_sequencer_pkg;

    localparam int PHASEW = 3;

    localparam logic [PHASEW-1:0] FETCH_PHASE = 3'd0;
    localparam logic [PHASEW-1:0] REG_PHASE   = 3'd1;
    localparam logic [PHASEW-1:0] EXEC_PHASE  = 3'd2;
    localparam logic [PHASEW-1:0] MEM_PHASE   = 3'd3;
    localparam logic [PHASEW-1:0] WB_PHASE    = 3'd4;
    localparam logic [PHASEW-1:0] HALT_PHASE  = 3'd5;
    localparam logic [PHASEW-1:0] FAULT_PHASE = 3'd6;

    localparam int WAIT_MAX_DEF = 15;
    localparam int CNTW_DEF     = 32;

    // State encoding equals the externally visible phase code
    typedef enum logic [PHASEW-1:0] {
        ST_FETCH = FETCH_PHASE,
        ST_REG   = REG_PHASE,
        ST_EXEC  = EXEC_PHASE,
        ST_MEM   = MEM_PHASE,
        ST_WB    = WB_PHASE,
        ST_HALT  = HALT_PHASE,
        ST_FAULT = FAULT_PHASE
    } state_t;

    function automatic logic [PHASEW-1:0] phase_of(input state_t s);
        return PHASEW'(s);
    endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// rtl/cpu_sequencer_wait_timer.sv - clearable up-counter with terminal count for the MEM timeout
module cpu_sequencer_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    // tc flags the last allowed wait cycle: count has reached LIMIT-1, so one
    // more unready cycle would make LIMIT. LIMIT=0 disables tc entirely.
    localparam int   W      = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam int   TC_VAL = (LIMIT > 0) ? LIMIT - 1 : 0;
    localparam logic TC_EN  = (LIMIT > 0);

    logic [W-1:0] count;

    // Count stalled MEM cycles; clear has priority over increment
    always_ff @(posedge clk) begin
        if (!nreset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign tc = TC_EN && (count == TC_VAL[W-1:0]);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - instruction phase sequencer with MEM stall, halt/step and timeout fault
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int CNTW     = CNTW_DEF
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              run,
    input  logic              step,
    input  logic              dec_mem_access,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic [PHASEW-1:0] phase,
    output logic              fetch_en,
    output logic              exec_en,
    output logic              mem_en,
    output logic              cpsr_we_en,
    output logic              wb_en,
    output logic              halted,
    output logic              fault,
    output logic [CNTW-1:0]   retired
);

    state_t state;
    state_t state_nxt;
    logic   step_mode;
    logic   mem_done;
    logic   tmr_clear;
    logic   tmr_inc;
    logic   tmr_tc;

    // MEM completes this cycle: either no access, or the memory answered
    assign mem_done   = (state == ST_MEM) && (!dec_mem_access || mem_ready);
    assign mem_en     = mem_done;
    assign cpsr_we_en = mem_done;

    // Wait counter is held clear outside MEM so it starts at zero on MEM entry
    assign tmr_clear = (state != ST_MEM);
    assign tmr_inc   = (state == ST_MEM) && dec_mem_access && !mem_ready;

    cpu_sequencer_wait_timer #(
        .LIMIT (WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .nreset (nreset),
        .clear  (tmr_clear),
        .inc    (tmr_inc),
        .tc     (tmr_tc)
    );

    // Next-state decode; a ready on the terminal wait cycle beats the timeout
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HALT:  if (run || step) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_REG;
            ST_REG:   state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = ST_MEM;
            ST_MEM: begin
                if (mem_done) begin
                    state_nxt = ST_WB;
                end else if (tmr_tc) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_WB:    state_nxt = (run && !step_mode) ? ST_FETCH : ST_HALT;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_HALT;
        endcase
    end

    // State, step mode, retire count and registered Moore outputs
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= ST_HALT;
            step_mode <= 1'b0;
            retired   <= '0;
            phase     <= HALT_PHASE;
            fetch_en  <= 1'b0;
            exec_en   <= 1'b0;
            wb_en     <= 1'b0;
            halted    <= 1'b1;
            fault     <= 1'b0;
            mem_req   <= 1'b0;
        end else begin
            state <= state_nxt;

            if ((state == ST_HALT) && (run || step)) begin
                step_mode <= !run;
            end else if ((state == ST_WB) && (state_nxt == ST_HALT)) begin
                step_mode <= 1'b0;
            end

            if (state == ST_WB) begin
                retired <= retired + CNTW'(1);
            end

            phase    <= phase_of(state_nxt);
            fetch_en <= (state_nxt == ST_FETCH);
            exec_en  <= (state_nxt == ST_EXEC);
            wb_en    <= (state_nxt == ST_WB);
            halted   <= (state_nxt == ST_HALT);
            fault    <= (state_nxt == ST_FAULT);
            mem_req  <= (state_nxt == ST_MEM) && dec_mem_access;
        end
    end

endmodule
